// File: rtl/data_path_if.sv
// Control and observation bundle for the single-bus datapath.
// The control unit (or bench) drives the master side; the datapath is the slave.
interface data_path_if #(
    parameter int DATA_WIDTH = 32
);
    // General register load enables and bus source selects
    logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
    logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;

    // Special register load enables
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in;

    // Special bus source selects
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;

    // ALU and memory controls
    logic                  IncPC;
    logic                  Mem_read;
    logic [4:0]            opcode;
    logic [DATA_WIDTH-1:0] MDR_Mem_lines;
    logic [DATA_WIDTH-1:0] Inport_data_in;

    // Observation outputs
    logic [DATA_WIDTH-1:0] MAR_to_chip, Outport_data_out;
    logic [DATA_WIDTH-1:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [DATA_WIDTH-1:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE;
    logic [DATA_WIDTH-1:0] BusMuxOut_out;

    modport master (
        output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
               R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
               R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
               R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
               IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in,
               HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
               IncPC, Mem_read, opcode, MDR_Mem_lines, Inport_data_in,
        input  MAR_to_chip, Outport_data_out, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
               regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE, BusMuxOut_out
    );

    modport slave (
        input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
               R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
               R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
               R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
               IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in,
               HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
               IncPC, Mem_read, opcode, MDR_Mem_lines, Inport_data_in,
        output MAR_to_chip, Outport_data_out, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
               regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE, BusMuxOut_out
    );
endinterface

// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, special registers, priority bus
// mux and a combinational ALU feeding the 64-bit Z register.
module data_path #(
    parameter int DATA_WIDTH = 32
) (
    input logic        clock,
    input logic        clear,
    data_path_if.slave bus_if
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [4:0] {
        OP_AND  = 5'b00001, OP_OR   = 5'b00010, OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100, OP_SHR  = 5'b00101, OP_SHRA = 5'b00110,
        OP_SHL  = 5'b00111, OP_ROR  = 5'b01000, OP_ROL  = 5'b01001,
        OP_MUL  = 5'b01010, OP_DIV  = 5'b01011, OP_NEG  = 5'b01100,
        OP_NOT  = 5'b01101
    } alu_op_e;

    logic [W-1:0]   regs_q [16];
    logic [W-1:0]   pc_q, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q, inport_q, outport_q;
    logic [2*W-1:0] z_q, z_d;
    logic [W-1:0]   mdr_d, bus;
    logic [15:0]    r_in, r_out;

    assign r_in  = {bus_if.R15in,  bus_if.R14in,  bus_if.R13in,  bus_if.R12in,
                    bus_if.R11in,  bus_if.R10in,  bus_if.R9in,   bus_if.R8in,
                    bus_if.R7in,   bus_if.R6in,   bus_if.R5in,   bus_if.R4in,
                    bus_if.R3in,   bus_if.R2in,   bus_if.R1in,   bus_if.R0in};
    assign r_out = {bus_if.R15out, bus_if.R14out, bus_if.R13out, bus_if.R12out,
                    bus_if.R11out, bus_if.R10out, bus_if.R9out,  bus_if.R8out,
                    bus_if.R7out,  bus_if.R6out,  bus_if.R5out,  bus_if.R4out,
                    bus_if.R3out,  bus_if.R2out,  bus_if.R1out,  bus_if.R0out};

    // Bus encoder: lowest-numbered general register wins, then the fixed special order
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves bus unassigned (no latch).
        bus = '0;
        if (|r_out) begin
            for (int i = 15; i >= 0; i--) begin
                if (r_out[i]) bus = regs_q[i];
            end
        end
        else if (bus_if.HIout)      bus = hi_q;
        else if (bus_if.LOout)      bus = lo_q;
        else if (bus_if.Zhi_out)    bus = z_q[2*W-1:W];
        else if (bus_if.Zlo_out)    bus = z_q[W-1:0];
        else if (bus_if.PCout)      bus = pc_q;
        else if (bus_if.MDRout)     bus = mdr_q;
        else if (bus_if.Inport_out) bus = inport_q;
        else if (bus_if.Cout)       bus = {{(W-19){ir_q[18]}}, ir_q[18:0]};
    end

    // ALU operands: A is Y, B is the bus; shift amount comes from the low bits of B
    logic [W-1:0]   alu_a, alu_b, quo, rem;
    logic [SW-1:0]  sh;
    logic [2*W-1:0] prod;

    assign alu_a = y_q;
    assign alu_b = bus;
    assign sh    = alu_b[SW-1:0];
    // Sign-extending both operands to 2W makes the truncated unsigned product the signed product
    assign prod  = {{W{alu_a[W-1]}}, alu_a} * {{W{alu_b[W-1]}}, alu_b};
    assign quo   = $signed(alu_a) / $signed(alu_b);
    assign rem   = $signed(alu_a) % $signed(alu_b);

    // ALU result selection; IncPC overrides the opcode for the fetch increment
    always_comb begin
        logic [2*W-1:0] rot;
        z_d = '0;
        rot = '0;
        case (opcode_e())
            OP_AND:  z_d[W-1:0] = alu_a & alu_b;
            OP_OR:   z_d[W-1:0] = alu_a | alu_b;
            OP_ADD:  z_d[W-1:0] = alu_a + alu_b;
            OP_SUB:  z_d[W-1:0] = alu_a - alu_b;
            OP_SHR:  z_d[W-1:0] = alu_a >> sh;
            OP_SHRA: z_d[W-1:0] = $signed(alu_a) >>> sh;
            OP_SHL:  z_d[W-1:0] = alu_a << sh;
            OP_ROR: begin
                rot        = {alu_a, alu_a} >> sh;
                z_d[W-1:0] = rot[W-1:0];
            end
            OP_ROL: begin
                rot        = {alu_a, alu_a} << sh;
                z_d[W-1:0] = rot[2*W-1:W];
            end
            OP_MUL:  z_d = prod;
            OP_DIV: begin
                if (alu_b != '0) z_d = {rem, quo};
            end
            OP_NEG:  z_d[W-1:0] = -alu_b;
            OP_NOT:  z_d[W-1:0] = ~alu_b;
            default: z_d = '0;
        endcase
        if (bus_if.IncPC) z_d = {{W{1'b0}}, alu_b + 1'b1};
    end

    function automatic alu_op_e opcode_e();
        return alu_op_e'(bus_if.opcode);
    endfunction

    assign mdr_d = bus_if.Mem_read ? bus_if.MDR_Mem_lines : bus;

    // All architectural registers: asynchronous clear, load-enabled capture
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            // NOTE: the register file is cleared too, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge bus, whatever the statement order.
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) regs_q[i] <= bus;
            end
            if (bus_if.PCin)       pc_q      <= bus;
            if (bus_if.IRin)       ir_q      <= bus;
            if (bus_if.RYin)       y_q       <= bus;
            if (bus_if.RZin)       z_q       <= z_d;
            if (bus_if.HIin)       hi_q      <= bus;
            if (bus_if.LOin)       lo_q      <= bus;
            if (bus_if.MARin)      mar_q     <= bus;
            if (bus_if.MDRin)      mdr_q     <= mdr_d;
            if (bus_if.Inport_in)  inport_q  <= bus_if.Inport_data_in;
            if (bus_if.Outport_in) outport_q <= bus;
        end
    end

    assign bus_if.MAR_to_chip      = mar_q;
    assign bus_if.Outport_data_out = outport_q;
    assign bus_if.reg1             = regs_q[1];
    assign bus_if.reg2             = regs_q[2];
    assign bus_if.reg3             = regs_q[3];
    assign bus_if.reg4             = regs_q[4];
    assign bus_if.reg5             = regs_q[5];
    assign bus_if.reg6             = regs_q[6];
    assign bus_if.reg7             = regs_q[7];
    assign bus_if.regMDR           = mdr_q;
    assign bus_if.PC_VALUE         = pc_q;
    assign bus_if.HI_VALUE         = hi_q;
    assign bus_if.LO_VALUE         = lo_q;
    assign bus_if.IR_VALUE         = ir_q;
    assign bus_if.BusMuxOut_out    = bus;
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: register loads, instruction micro-sequences,
// ALU operations, bus priority and asynchronous clear.
module tb_data_path;
    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] rin, rout;
    int          checks   = 0;
    int          failures = 0;

    data_path_if dp_if ();
    data_path dut (.clock(clock), .clear(clear), .bus_if(dp_if));

    always #5 clock = ~clock;

    assign dp_if.R0in  = rin[0];   assign dp_if.R1in  = rin[1];
    assign dp_if.R2in  = rin[2];   assign dp_if.R3in  = rin[3];
    assign dp_if.R4in  = rin[4];   assign dp_if.R5in  = rin[5];
    assign dp_if.R6in  = rin[6];   assign dp_if.R7in  = rin[7];
    assign dp_if.R8in  = rin[8];   assign dp_if.R9in  = rin[9];
    assign dp_if.R10in = rin[10];  assign dp_if.R11in = rin[11];
    assign dp_if.R12in = rin[12];  assign dp_if.R13in = rin[13];
    assign dp_if.R14in = rin[14];  assign dp_if.R15in = rin[15];
    assign dp_if.R0out  = rout[0];  assign dp_if.R1out  = rout[1];
    assign dp_if.R2out  = rout[2];  assign dp_if.R3out  = rout[3];
    assign dp_if.R4out  = rout[4];  assign dp_if.R5out  = rout[5];
    assign dp_if.R6out  = rout[6];  assign dp_if.R7out  = rout[7];
    assign dp_if.R8out  = rout[8];  assign dp_if.R9out  = rout[9];
    assign dp_if.R10out = rout[10]; assign dp_if.R11out = rout[11];
    assign dp_if.R12out = rout[12]; assign dp_if.R13out = rout[13];
    assign dp_if.R14out = rout[14]; assign dp_if.R15out = rout[15];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rin = '0; rout = '0;
        dp_if.IRin = 0; dp_if.PCin = 0; dp_if.RYin = 0; dp_if.RZin = 0; dp_if.MARin = 0;
        dp_if.MDRin = 0; dp_if.HIin = 0; dp_if.LOin = 0; dp_if.Outport_in = 0; dp_if.Inport_in = 0;
        dp_if.HIout = 0; dp_if.LOout = 0; dp_if.Zhi_out = 0; dp_if.Zlo_out = 0; dp_if.PCout = 0;
        dp_if.MDRout = 0; dp_if.Inport_out = 0; dp_if.Cout = 0;
        dp_if.IncPC = 0; dp_if.Mem_read = 0; dp_if.opcode = 5'b0;
    endtask

    // One micro-step: the controls set beforehand take effect on this edge
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] val);
        dp_if.MDR_Mem_lines = val; dp_if.Mem_read = 1; dp_if.MDRin = 1;
        tick();
    endtask

    // T0..T5 instruction sequence with Ra=R1, Rb=R2, Rc=R3
    task automatic instr(input logic [4:0] op, input logic [31:0] ir_word);
        dp_if.PCout = 1; dp_if.IncPC = 1; dp_if.MARin = 1; dp_if.RZin = 1; tick();
        dp_if.Zlo_out = 1; dp_if.PCin = 1; dp_if.Mem_read = 1; dp_if.MDRin = 1;
        dp_if.MDR_Mem_lines = ir_word; tick();
        dp_if.MDRout = 1; dp_if.IRin = 1; tick();
        rout[2] = 1; dp_if.RYin = 1; tick();
        rout[3] = 1; dp_if.opcode = op; dp_if.RZin = 1; tick();
        dp_if.Zlo_out = 1; rin[1] = 1; tick();
    endtask

    // Y <- y, then Z <- ALU(Y, b), then HI/LO <- Z halves and compare
    task automatic alu_case(input string tag, input logic [31:0] y, input logic [31:0] b,
                            input logic [4:0] op, input logic inc,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        load_mdr(y);
        dp_if.MDRout = 1; dp_if.RYin = 1; tick();
        load_mdr(b);
        dp_if.MDRout = 1; dp_if.opcode = op; dp_if.IncPC = inc; dp_if.RZin = 1; tick();
        dp_if.Zlo_out = 1; dp_if.LOin = 1; tick();
        dp_if.Zhi_out = 1; dp_if.HIin = 1; tick();
        check({tag, "_lo"}, {32'b0, dp_if.LO_VALUE}, {32'b0, exp_lo});
        check({tag, "_hi"}, {32'b0, dp_if.HI_VALUE}, {32'b0, exp_hi});
    endtask

    initial begin
        clear = 1'b1;
        idle();
        dp_if.MDR_Mem_lines  = '0;
        dp_if.Inport_data_in = '0;
        #12;
        check("rst_pc",  {32'b0, dp_if.PC_VALUE},      64'h0);
        check("rst_r1",  {32'b0, dp_if.reg1},          64'h0);
        check("rst_mar", {32'b0, dp_if.MAR_to_chip},   64'h0);
        check("rst_mdr", {32'b0, dp_if.regMDR},        64'h0);
        check("rst_bus", {32'b0, dp_if.BusMuxOut_out}, 64'h0);
        @(negedge clock);
        clear = 1'b0;

        // Operand setup through MDR
        load_mdr(32'h10);
        check("mdr_mem", {32'b0, dp_if.regMDR}, 64'h10);
        dp_if.MDRout = 1; rin[2] = 1; dp_if.PCin = 1; tick();
        check("r2_load", {32'b0, dp_if.reg2},     64'h10);
        check("pc_load", {32'b0, dp_if.PC_VALUE}, 64'h10);
        load_mdr(32'h14);
        dp_if.MDRout = 1; rin[3] = 1; tick();
        load_mdr(32'h18);
        dp_if.MDRout = 1; rin[1] = 1; tick();
        check("r3_load", {32'b0, dp_if.reg3}, 64'h14);
        check("r1_load", {32'b0, dp_if.reg1}, 64'h18);

        // ADD then SUB instruction sequences
        instr(5'b00011, 32'h2891_8000);
        check("add_pc",  {32'b0, dp_if.PC_VALUE},    64'h11);
        check("add_ir",  {32'b0, dp_if.IR_VALUE},    64'h2891_8000);
        check("add_mar", {32'b0, dp_if.MAR_to_chip}, 64'h10);
        check("add_r1",  {32'b0, dp_if.reg1},        64'h24);
        instr(5'b00100, 32'h2891_8000);
        check("sub_pc",  {32'b0, dp_if.PC_VALUE},    64'h12);
        check("sub_mar", {32'b0, dp_if.MAR_to_chip}, 64'h11);
        check("sub_r1",  {32'b0, dp_if.reg1},        64'hFFFF_FFFC);

        // Bus priority and the sign-extended constant path
        rout[1] = 1; dp_if.MDRout = 1; #1;
        check("prio_r1_mdr", {32'b0, dp_if.BusMuxOut_out}, 64'hFFFF_FFFC);
        idle(); dp_if.Cout = 1; #1;
        check("cout_pos", {32'b0, dp_if.BusMuxOut_out}, 64'h0001_8000);
        idle(); #1;
        check("bus_none", {32'b0, dp_if.BusMuxOut_out}, 64'h0);

        // Multiply and divide, split through HI/LO
        alu_case("mul", 32'hFFFF_FFFE, 32'h3, 5'b01010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        alu_case("div", 32'h7, 32'hFFFF_FFFE, 5'b01011, 1'b0, 32'h1, 32'hFFFF_FFFD);
        dp_if.HIout = 1; dp_if.LOout = 1; dp_if.PCout = 1; #1;
        check("prio_hi_lo", {32'b0, dp_if.BusMuxOut_out}, 64'h1);
        idle();

        // Remaining ALU operations and boundary cases
        alu_case("and",  32'hF0F0_1234, 32'h0FF0_FF00, 5'b00001, 1'b0, 32'h0, 32'h00F0_1200);
        alu_case("or",   32'hF0F0_1234, 32'h0FF0_FF00, 5'b00010, 1'b0, 32'h0, 32'hFFF0_FF34);
        alu_case("addw", 32'hFFFF_FFFF, 32'h2,         5'b00011, 1'b0, 32'h0, 32'h1);
        alu_case("shr",  32'h8000_0010, 32'h4,         5'b00101, 1'b0, 32'h0, 32'h0800_0001);
        alu_case("shra", 32'h8000_0010, 32'h4,         5'b00110, 1'b0, 32'h0, 32'hF800_0001);
        alu_case("shl",  32'h8000_0011, 32'h24,        5'b00111, 1'b0, 32'h0, 32'h0000_0110);
        alu_case("ror",  32'h1234_5678, 32'h8,         5'b01000, 1'b0, 32'h0, 32'h7812_3456);
        alu_case("rol",  32'h1234_5678, 32'h8,         5'b01001, 1'b0, 32'h0, 32'h3456_7812);
        alu_case("neg",  32'h0,         32'h5,         5'b01100, 1'b0, 32'h0, 32'hFFFF_FFFB);
        alu_case("not",  32'h0,         32'h0F0F_0F0F, 5'b01101, 1'b0, 32'h0, 32'hF0F0_F0F0);
        alu_case("inv",  32'h1,         32'h2,         5'b11111, 1'b0, 32'h0, 32'h0);
        alu_case("div0", 32'h7,         32'h0,         5'b01011, 1'b0, 32'h0, 32'h0);
        alu_case("incpc",32'h100,       32'h41,        5'b00011, 1'b1, 32'h0, 32'h42);

        // Negative constant field
        load_mdr(32'h0004_0000);
        dp_if.MDRout = 1; dp_if.IRin = 1; tick();
        dp_if.Cout = 1; #1;
        check("cout_neg", {32'b0, dp_if.BusMuxOut_out}, 64'hFFFC_0000);
        idle();

        // In-port captures external data, not the bus; out-port takes the bus
        dp_if.Inport_data_in = 32'hCAFE_BABE; dp_if.Inport_in = 1; dp_if.PCout = 1; tick();
        dp_if.Inport_out = 1; dp_if.Outport_in = 1; tick();
        check("outport", {32'b0, dp_if.Outport_data_out}, 64'hCAFE_BABE);

        // R0 behaves as an ordinary register and outranks R1 on the bus
        load_mdr(32'hA5A5_0001);
        dp_if.MDRout = 1; rin[0] = 1; tick();
        rout[0] = 1; rin[4] = 1; tick();
        check("r0_to_r4", {32'b0, dp_if.reg4}, 64'hA5A5_0001);
        rout[0] = 1; rout[1] = 1; #1;
        check("prio_r0_r1", {32'b0, dp_if.BusMuxOut_out}, 64'hA5A5_0001);
        idle();

        // Asynchronous clear between clock edges, in the middle of a fetch step
        dp_if.PCout = 1; dp_if.IncPC = 1; dp_if.MARin = 1; dp_if.RZin = 1;
        #2;
        clear = 1'b1;
        #1;
        check("clr_pc",  {32'b0, dp_if.PC_VALUE},         64'h0);
        check("clr_ir",  {32'b0, dp_if.IR_VALUE},         64'h0);
        check("clr_r4",  {32'b0, dp_if.reg4},             64'h0);
        check("clr_hi",  {32'b0, dp_if.HI_VALUE},         64'h0);
        check("clr_lo",  {32'b0, dp_if.LO_VALUE},         64'h0);
        check("clr_mdr", {32'b0, dp_if.regMDR},           64'h0);
        check("clr_out", {32'b0, dp_if.Outport_data_out}, 64'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Single-bus 32-bit CPU datapath (phase-1): 16 general registers R0–R15 plus PC, IR, Y, Z (64-bit), HI, LO, MAR, MDR, in-port and out-port registers around one shared 32-bit bus.
- An ALU combines Y with the bus into Z.
- All control is supplied externally, one signal per micro-operation, by a control unit or bench.
- Internal values are exposed on observation ports for verification.

Parameters:
- DATA_WIDTH, 32, width of bus and all registers except Z; Z is 2×DATA_WIDTH.

Ports:
- clock  in  1  rising-edge clock for every register
- clear  in  1  asynchronous active-high reset of all registers
- R0in..R15in  in  1 each  load general register Rn from bus
- IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in  in  1 each  register load enables
- IncPC  in  1  ALU override: Z ← bus + 1
- R0out..R15out, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  in  1 each  bus source selects
- Mem_read  in  1  MDR input select: 1 = memory data, 0 = bus
- MDR_Mem_lines  in  32  memory read data
- Inport_data_in  in  32  external input-port data
- opcode  in  5  ALU operation select
- MAR_to_chip  out  32  MAR contents, used as memory address
- Outport_data_out  out  32  out-port register contents
- reg1..reg7  out  32 each  R1–R7 contents
- regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE  out  32 each  register contents
- BusMuxOut_out  out  32  current bus value

Behaviour:
- Every register clears to 0 asynchronously on clear = 1. All outputs are therefore 0 during reset, except BusMuxOut_out, which shows the bus value.
- Register loads: on a rising clock edge with the enable high, the register captures the bus.
- MDR exception: with MDRin high, MDR captures MDR_Mem_lines when Mem_read = 1, and the bus otherwise.
- In-port exception: with Inport_in high, the in-port register captures Inport_data_in.
- Z is 64 bits and loads on RZin. Zhi_out drives Z[63:32] onto the bus; Zlo_out drives Z[31:0].
- R0 is an ordinary register in this phase.
- Bus is a combinational encoder/mux. If several selects are high, the first in this order wins: R0..R15, HI, LO, Zhi, Zlo, PC, MDR, Inport, C.
- With no select high, the bus is 0.
- Cout drives IR[18:0] sign-extended to 32 bits.
- ALU is combinational. Operand A = Y, operand B = bus; the result goes to Z. Z changes only on a clock edge with RZin high.
- IncPC = 1 forces Z = {32'b0, B + 1}, regardless of opcode.
- Opcodes; single-word results are zero-extended into Z[63:32]:
  - 00001 AND
  - 00010 OR
  - 00011 ADD: A+B, wraps mod 2^32
  - 00100 SUB: A−B, wraps
  - 00101 SHR logical
  - 00110 SHRA arithmetic
  - 00111 SHL
  - 01000 ROR
  - 01001 ROL
  - 01010 MUL: signed 64-bit product into Z
  - 01011 DIV signed: Z[31:0] = quotient, Z[63:32] = remainder
  - 01100 NEG: −B
  - 01101 NOT: ~B
  - all other opcodes: Z = 0
- Shift and rotate amount is B[4:0].
- DIV by zero gives Z = 0.
- The bench-level instruction protocol is multi-cycle:
  - T0: PCout, IncPC, MARin, RZin
  - T1: Zlo_out, PCin, Mem_read, MDRin
  - T2: MDRout, IRin
  - T3: Rb out, RYin
  - T4: Rc out, opcode, RZin
  - T5: Zlo_out, Ra in
- Each step takes effect on one rising edge.
- The datapath does not decode IR.

Test Plan:
- Load sequence: MDR ← 0x10 via Mem_read; then MDRout with R2in and PCin → R2 = PC = 0x10. Then R3 ← 0x14 and R1 ← 0x18 through MDR.
- ADD T0–T5 with IR fetch data 0x28918000, opcode 00011, R2 then R3 → PC = 0x11, IR = 0x28918000, MAR = 0x10, R1 = 0x24.
- SUB immediately after, same sequence, opcode 00100 → PC = 0x12, R1 = 0xFFFFFFFC.
- MUL with Y = 0xFFFFFFFE and B = 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA after Zhi_out/HIin and Zlo_out/LOin. DIV 7/−2 → LO = 0xFFFFFFFD, HI = 1.
- Bus priority: R1out and MDRout together → BusMuxOut_out = R1.
- Cout with IR[18:0] = 0x40000 → bus = 0xFFFC0000.
- clear pulse mid-operation → all registers 0 immediately, without a clock.
